// File: rtl/l2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : l2_arbiter
//  Description : Round-robin arbiter sharing the unified L2 port between the
//                I-side and D-side L1 caches. Latches the winning request,
//                holds it on the L2 port until l2_resp, routes the one-cycle
//                response back to the owner, and counts grants per side.
//  Revision    : 1.0  initial release
// ============================================================================
module l2_arbiter (
   input  logic         clk,
   input  logic         rst_n,
   // I-side L1
   input  logic         i_read,
   input  logic         i_write,
   input  logic [15:0]  i_address,
   input  logic [127:0] i_wdata,
   output logic         i_resp,
   output logic [127:0] i_rdata,
   // D-side L1
   input  logic         d_read,
   input  logic         d_write,
   input  logic [15:0]  d_address,
   input  logic [127:0] d_wdata,
   output logic         d_resp,
   output logic [127:0] d_rdata,
   // L2 port
   output logic         l2_read,
   output logic         l2_write,
   output logic [15:0]  l2_address,
   output logic [127:0] l2_wdata,
   input  logic         l2_resp,
   input  logic [127:0] l2_rdata,
   // grant counters
   output logic [15:0]  i_grants,
   output logic [15:0]  d_grants
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } state_t;

   state_t         state_q,    state_d;
   logic           last_d_q,   last_d_d;    // 1: most recent grant went to D
   logic           op_write_q, op_write_d;
   logic [15:0]    addr_q,     addr_d;
   logic [127:0]   wdata_q,    wdata_d;
   logic [15:0]    i_grants_q, i_grants_d;
   logic [15:0]    d_grants_q, d_grants_d;

   logic           i_pend;
   logic           d_pend;

   assign i_pend = i_read | i_write;
   assign d_pend = d_read | d_write;

   // Arbitration, request latching and response steering.
   always_comb begin
      state_d    = state_q;
      last_d_d   = last_d_q;
      op_write_d = op_write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      i_grants_d = i_grants_q;
      d_grants_d = d_grants_q;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
      l2_read    = 1'b0;
      l2_write   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // I wins when alone, or on a tie if D was granted last.
            if (i_pend && (!d_pend || last_d_q)) begin
               state_d    = ST_BUSY_I;
               last_d_d   = 1'b0;
               op_write_d = i_write;   // read+write together counts as write
               addr_d     = i_address;
               wdata_d    = i_wdata;
               i_grants_d = i_grants_q + 16'd1;
            end else if (d_pend) begin
               state_d    = ST_BUSY_D;
               last_d_d   = 1'b1;
               op_write_d = d_write;
               addr_d     = d_address;
               wdata_d    = d_wdata;
               d_grants_d = d_grants_q + 16'd1;
            end
         end
         ST_BUSY_I: begin
            l2_read  = ~op_write_q;
            l2_write = op_write_q;
            if (l2_resp) begin
               i_resp  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_BUSY_D: begin
            l2_read  = ~op_write_q;
            l2_write = op_write_q;
            if (l2_resp) begin
               d_resp  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign l2_address = addr_q;
   assign l2_wdata   = wdata_q;
   assign i_rdata    = l2_rdata;
   assign d_rdata    = l2_rdata;
   assign i_grants   = i_grants_q;
   assign d_grants   = d_grants_q;

   // State registers; reset abandons any in-flight transaction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         last_d_q   <= 1'b1;
         op_write_q <= 1'b0;
         addr_q     <= 16'h0000;
         wdata_q    <= 128'd0;
         i_grants_q <= 16'd0;
         d_grants_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         last_d_q   <= last_d_d;
         op_write_q <= op_write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         i_grants_q <= i_grants_d;
         d_grants_q <= d_grants_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/l2_arbiter.md
# l2_arbiter

Round-robin arbiter that shares the single unified L2 cache port between the instruction-side and data-side L1 caches. It accepts line-sized read/write requests from both L1s, grants one at a time, holds the granted request stable on the L2 port until the L2 responds, and routes the one-cycle response back to the owner. It sits between the split L1 caches and the L2 cache's `mem_*` interface, and keeps per-port grant counters for performance visibility.

## Interface
- No parameters. Word = lc3b_word (16 bits), line = lc3b_line (128 bits).
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- i_read  input  1  I-side line read request; held until i_resp
- i_write  input  1  I-side line write request; held until i_resp
- i_address  input  16  I-side line address
- i_wdata  input  128  I-side write line
- i_resp  output  1  one-cycle completion pulse to I-side
- i_rdata  output  128  read line to I-side
- d_read, d_write, d_address, d_wdata, d_resp, d_rdata  same as the i_* ports, for the D-side
- l2_read  output  1  read request to L2
- l2_write  output  1  write request to L2
- l2_address  output  16  latched address to L2
- l2_wdata  output  128  latched write line to L2
- l2_resp  input  1  L2 completion pulse
- l2_rdata  input  128  L2 read line
- i_grants  output  16  count of I-side grants, wraps
- d_grants  output  16  count of D-side grants, wraps

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: requester x is pending when x_read or x_write. Neither pending -> stay. One pending -> grant it. Both pending -> grant the side not granted last (last_grant register).
- On grant, register op (read/write), address and wdata from the winner; go to BUSY_x; update last_grant; increment x_grants (mod 2^16).
- Same requester asserting read and write together: treat as write.
- BUSY_x: l2_read/l2_write driven from the latched op, l2_address/l2_wdata from latched values; inputs from both requesters are ignored.
- BUSY_x with l2_resp=1: x_resp = 1 that cycle (combinational from l2_resp and state); next state IDLE; l2_read/l2_write deassert in IDLE.
- i_rdata = d_rdata = l2_rdata at all times; valid only while the matching resp is high.
- l2_resp in IDLE is ignored; no resp is generated.
- The non-granted side never sees resp; its request stays pending and is granted from the following IDLE.
- A requester dropping its request while BUSY does not abort; L2 completes, resp still pulses.
- Reset: state IDLE, last_grant = D (so I wins the first tie), latched op/address/wdata = 0, both counters = 0. Reset mid-transaction abandons it with no resp; the requester must re-issue.

## Timing
- Reset values: l2_read=0, l2_write=0, l2_address=0x0000, l2_wdata=0, i_resp=0, d_resp=0, i_grants=0, d_grants=0.
- Grant latency: request seen in IDLE at cycle t -> l2_read/l2_write high from cycle t+1.
- Completion: l2_resp at cycle n -> x_resp at cycle n (zero latency); IDLE at n+1; earliest next grant at n+1, next L2 request at n+2.
- Each transaction costs at least one IDLE cycle between L2 requests, so the L2 sees its request deasserted after every resp.
- L2 request signals stay constant for the entire BUSY state regardless of requester input changes.
- Both pending continuously: grants strictly alternate I, D, I, D...

## Test plan
- Single I read: i_read=1, i_address=0x1230 in IDLE -> cycle+1 l2_read=1, l2_address=0x1230; L2 returns l2_rdata=0xAAAA...A with l2_resp -> i_resp=1, i_rdata=0xAAAA...A same cycle, d_resp=0; i_grants=1.
- Simultaneous requests after reset: i_read at 0x1000, d_write at 0x2000 with d_wdata=0x5555...5 -> I served first (l2_address=0x1000), then D (l2_write=1, l2_address=0x2000, l2_wdata=0x5555...5); exactly one i_resp and one d_resp.
- Continuous contention for 6 transactions -> grant order I,D,I,D,I,D; i_grants=3, d_grants=3; l2 request low for one cycle between each.
- Input change during BUSY: D granted at 0x2000, then d_address changes to 0x3000 and i_read rises -> l2_address stays 0x2000 until l2_resp; I granted next.
- Reset mid-transaction: rst_n=0 while BUSY_I -> next cycle l2_read=0, no i_resp, counters 0; after release, pending i_read re-granted.
- Spurious l2_resp in IDLE -> i_resp=d_resp=0, state and counters unchanged; counter wrap: 65536 I grants -> i_grants returns to 0.
